fifo_sync_flags: RTL and testbench
==================================

FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, DEPTH-2, level at or above which almost_full asserts.
- AEMPTY_THRESH, 2, level at or below which almost_empty asserts.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, asynchronous, active-high reset.
- wr_en, input, 1, write request.
- wr_data, input, DATA_WIDTH, write data.
- full, output, 1, level == DEPTH.
- almost_full, output, 1, level >= AFULL_THRESH.
- overflow, output, 1, sticky: write attempted while full.
- rd_en, input, 1, read request (pop).
- rd_data, output, DATA_WIDTH, read data.
- rd_valid, output, 1, rd_data holds valid data.
- empty, output, 1, level == 0.
- almost_empty, output, 1, level <= AEMPTY_THRESH.
- underflow, output, 1, sticky: read attempted while empty.
- level, output, ADDR_WIDTH+1, current entry count, 0..DEPTH.
- clr_err, input, 1, synchronous clear of overflow and underflow.

REQ-003 Design SHALL have one clock, clk, and one reset, rst; rst is asynchronous and active-high.

Function
REQ-004 Storage SHALL be DEPTH x DATA_WIDTH.
REQ-005 Read and write pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
REQ-006 A write SHALL be accepted iff wr_en && !full; an accepted write stores wr_data at wr_ptr and increments wr_ptr.
REQ-007 A read SHALL be accepted iff rd_en && !empty; an accepted read increments rd_ptr.
REQ-008 level SHALL be registered and update as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-009 full, empty, almost_full and almost_empty SHALL be decoded from the registered level, so they reflect the prior edge's level with no extra lag.
REQ-010 Simultaneous wr_en and rd_en when empty: write accepted, read rejected, underflow set, level 0->1.
REQ-011 Simultaneous wr_en and rd_en when full: read accepted, write rejected, overflow set, level DEPTH->DEPTH-1.
REQ-012 Simultaneous accepted write and read at any other level: both performed, level unchanged.
REQ-013 FWFT=0: rd_data SHALL be registered with mem[rd_ptr] on the edge accepting a read; rd_valid pulses high for exactly the following cycle; rd_data holds its value otherwise.
REQ-014 FWFT=1: rd_data SHALL equal mem[rd_ptr] combinationally and rd_valid = !empty; rd_en acts as an acknowledge/pop.
REQ-015 FWFT=1: first write into an empty FIFO SHALL make rd_valid high on the cycle after the write edge.
REQ-016 overflow SHALL be set on any edge with wr_en && full; underflow SHALL be set on any edge with rd_en && empty.
REQ-017 Both flags SHALL hold until clr_err; if set and clr_err occur on the same edge, set wins.
REQ-018 Rejected accesses SHALL change no pointer, no level and no storage.
REQ-019 Threshold parameters SHALL satisfy 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH; violation is an elaboration error.

Reset
REQ-020 On rst assertion, immediately and asynchronously: pointers = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, rd_valid = 0, rd_data = 0 (FWFT=0).
REQ-021 Reset mid-operation SHALL discard all contents; storage array contents need not reset.
REQ-022 First access SHALL be honoured on the first posedge after rst deasserts.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, AFULL_THRESH=14, AEMPTY_THRESH=2)
REQ-023 Fill/drain, FWFT=0:
- 16 writes 0x00..0x0F -> full=1, level=16; almost_full from level 14.
- 16 reads -> rd_data 0x00..0x0F, each one cycle after its rd_en, in order; empty=1 at end.
REQ-024 Overflow/underflow:
- write 0xAA while full -> overflow=1, level stays 16, data unchanged.
- clr_err -> overflow=0.
- rd_en while empty -> underflow=1.
REQ-025 Simultaneous access:
- at level 8, wr_en and rd_en for 20 cycles -> level stays 8, data in order.
- at level 0, both asserted -> level=1, underflow=1.
REQ-026 Wrap-around: 40 writes/reads interleaved at level 5 -> pointers wrap, no data loss, no flag change.
REQ-027 FWFT=1: write 0x5C into empty FIFO -> next cycle rd_valid=1, rd_data=0x5C with no rd_en; rd_en -> empty=1.
REQ-028 Reset mid-operation: rst pulse at level 9 -> level=0, empty=1, flags=0 within the reset cycle; next write 0x11 reads back 0x11.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered level, threshold flags and sticky error flags.
// FWFT selects a registered read port or a first-word-fall-through read port.
module fifo_sync_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   level,
  input  logic                  clr_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  if (!((AEMPTY_THRESH > 0) && (AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH)))
  begin : g_thresh_check
    $error("fifo_sync_flags: thresholds must satisfy 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] head_data;

  // All status flags come straight from the registered level.
  assign full         = (level_q == DEPTH_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AFULL_LVL);
  assign almost_empty = (level_q <= AEMPTY_LVL);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;
  assign head_data = mem[rd_ptr_q];

  assign rd_data  = (FWFT != 0) ? head_data : rd_data_q;
  assign rd_valid = (FWFT != 0) ? !empty : rd_valid_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = head_data;
      rd_valid_d = 1'b1;
    end

    case ({wr_accept, rd_accept})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A new error on the same edge as clr_err takes priority over the clear.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags: a registered-read instance driven
// through a queue scoreboard, plus a first-word-fall-through instance.
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic       full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
  logic [7:0] rd_data;
  logic [4:0] level;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data;
  logic       f_full, f_almost_full, f_overflow, f_rd_valid, f_empty, f_almost_empty, f_underflow;
  logic [7:0] f_rd_data;
  logic [4:0] f_level;

  fifo_sync_flags #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .underflow(underflow),
    .level(level), .clr_err(clr_err)
  );

  fifo_sync_flags #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_almost_full),
    .overflow(f_overflow), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .empty(f_empty), .almost_empty(f_almost_empty), .underflow(f_underflow),
    .level(f_level), .clr_err(f_clr_err)
  );

  int total = 0;
  int bad = 0;

  // Reference model: expected read data in write order plus expected level/flags.
  logic [7:0] sbq[$];
  int         mLevel = 0;
  bit         mOver = 1'b0;
  bit         mUnder = 1'b0;

  // One comparison: counts it, and reports tag/observed/expected when it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the registered-read instance, update the model across
  // the edge, then compare every output shortly after the edge.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit         fullM, emptyM, wa, ra;
    logic [7:0] expData;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    fullM  = (mLevel == 16);
    emptyM = (mLevel == 0);
    wa = w && !fullM;
    ra = r && !emptyM;
    @(posedge clk);
    #1;
    if (wa) sbq.push_back(d);
    if (ra) begin
      expData = sbq.pop_front();
      checkOutput("rd_valid", {31'd0, rd_valid}, 32'd1);
      checkOutput("rd_data", {24'd0, rd_data}, {24'd0, expData});
    end else begin
      checkOutput("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
    end
    if (wa && !ra) mLevel++;
    if (ra && !wa) mLevel--;
    mOver  = (mOver && !c) || (w && fullM);
    mUnder = (mUnder && !c) || (r && emptyM);
    checkOutput("level", {27'd0, level}, mLevel);
    checkOutput("full", {31'd0, full}, (mLevel == 16));
    checkOutput("empty", {31'd0, empty}, (mLevel == 0));
    checkOutput("almost_full", {31'd0, almost_full}, (mLevel >= 14));
    checkOutput("almost_empty", {31'd0, almost_empty}, (mLevel <= 2));
    checkOutput("overflow", {31'd0, overflow}, {31'd0, mOver});
    checkOutput("underflow", {31'd0, underflow}, {31'd0, mUnder});
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; rd_en = 0; clr_err = 0; wr_data = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_level", {27'd0, level}, 32'd0);
    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_aempty", {31'd0, almost_empty}, 32'd1);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_afull", {31'd0, almost_full}, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x00..0x0F, then overflow with set-wins-over-clear.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain, then check rd_data holds after the valid pulse.
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rd_data_hold", {24'd0, rd_data}, 32'h0F);

    // Underflow, then simultaneous access on an empty FIFO.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Level 8 with 20 cycles of simultaneous read and write.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);

    // Simultaneous access while full: only the read is taken.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);

    // Down to level 5, then 40 interleaved writes/reads so both pointers wrap.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      else            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Up to level 9 with overflow still set, then an asynchronous reset pulse.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 0; rd_en = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_level", {27'd0, level}, 32'd0);
    checkOutput("arst_empty", {31'd0, empty}, 32'd1);
    checkOutput("arst_full", {31'd0, full}, 32'd0);
    checkOutput("arst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("arst_underflow", {31'd0, underflow}, 32'd0);
    checkOutput("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("arst_rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    mLevel = 0; mOver = 1'b0; mUnder = 1'b0;
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // First-word-fall-through instance.
    checkOutput("fwft_idle_valid", {31'd0, f_rd_valid}, 32'd0);
    @(negedge clk);
    f_wr_en = 1'b1; f_wr_data = 8'h5C;
    @(posedge clk);
    #1;
    checkOutput("fwft_valid", {31'd0, f_rd_valid}, 32'd1);
    checkOutput("fwft_data", {24'd0, f_rd_data}, 32'h5C);
    @(negedge clk);
    f_wr_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("fwft_valid_hold", {31'd0, f_rd_valid}, 32'd1);
    @(negedge clk);
    f_rd_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("fwft_pop_empty", {31'd0, f_empty}, 32'd1);
    checkOutput("fwft_pop_valid", {31'd0, f_rd_valid}, 32'd0);
    checkOutput("fwft_pop_underflow", {31'd0, f_underflow}, 32'd0);
    @(negedge clk);
    f_rd_en = 1'b0; f_wr_en = 1'b1; f_wr_data = 8'hA1;
    @(negedge clk);
    f_wr_data = 8'hA2;
    @(negedge clk);
    f_wr_en = 1'b0;
    checkOutput("fwft_head_a1", {24'd0, f_rd_data}, 32'hA1);
    f_rd_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("fwft_head_a2", {24'd0, f_rd_data}, 32'hA2);
    checkOutput("fwft_level", {27'd0, f_level}, 32'd1);
    @(negedge clk);
    f_rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
